// File: rtl/sha3_lane_buffer.sv
// rtl/sha3_lane_buffer.sv - 25x64-bit Keccak lane buffer between dmem and the SHA-3 core
module sha3_lane_buffer #(
    parameter int LANES = 25,
    parameter int W     = 64,
    parameter int IDX_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [63:0]      cmd_base,
    output logic             cmd_ready,
    output logic [63:0]      dmem_addr,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic [W-1:0]     dmem_wdata,
    input  logic [W-1:0]     dmem_rdata,
    output logic             core_out_valid,
    output logic [W-1:0]     core_out_data,
    input  logic             core_out_ready,
    input  logic             core_in_valid,
    input  logic [W-1:0]     core_in_data,
    output logic             core_in_ready,
    output logic [IDX_W-1:0] lane_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_LAST,
        S_STORE,
        S_ABSORB,
        S_SQUEEZE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state;
    logic [63:0]      base;
    logic [IDX_W-1:0] idx;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [W-1:0]     lanes [LANES];
    logic             is_last;
    logic             mem_active;

    assign is_last    = (idx == LAST_IDX);
    assign mem_active = (state == S_LOAD) || (state == S_STORE);

    // Command FSM, lane index walk and lane storage; dmem read data lands one cycle after its read
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            base   <= '0;
            idx    <= '0;
            wr_en  <= 1'b0;
            wr_idx <= '0;
            for (int i = 0; i < LANES; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            wr_en  <= (state == S_LOAD);
            wr_idx <= idx;
            if (wr_en) begin
                lanes[wr_idx] <= dmem_rdata;
            end
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        base <= cmd_base;
                        idx  <= '0;
                        case (cmd_op)
                            2'b00:   state <= S_LOAD;
                            2'b01:   state <= S_STORE;
                            2'b10:   state <= S_ABSORB;
                            default: state <= S_SQUEEZE;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (is_last) state <= S_LOAD_LAST;
                    else         idx   <= idx + IDX_ONE;
                end
                S_LOAD_LAST: begin
                    state <= S_DONE;
                end
                S_STORE: begin
                    if (is_last) state <= S_DONE;
                    else         idx   <= idx + IDX_ONE;
                end
                S_ABSORB: begin
                    if (core_out_ready) begin
                        if (is_last) state <= S_DONE;
                        else         idx   <= idx + IDX_ONE;
                    end
                end
                S_SQUEEZE: begin
                    if (core_in_valid) begin
                        lanes[idx] <= core_in_data;
                        if (is_last) state <= S_DONE;
                        else         idx   <= idx + IDX_ONE;
                    end
                end
                S_DONE: begin
                    idx   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode only from state, lane index and lane registers
    always_comb begin
        cmd_ready      = (state == S_IDLE);
        busy           = (state != S_IDLE);
        done           = (state == S_DONE);
        dmem_re        = (state == S_LOAD);
        dmem_we        = (state == S_STORE);
        dmem_addr      = mem_active ? (base + (64'(idx) << 3)) : 64'd0;
        dmem_wdata     = (state == S_STORE) ? lanes[idx] : '0;
        core_out_valid = (state == S_ABSORB);
        core_out_data  = (state == S_ABSORB) ? lanes[idx] : '0;
        core_in_ready  = (state == S_SQUEEZE);
        lane_idx       = idx;
    end

endmodule

// File: doc/sha3_lane_buffer.md
# sha3_lane_buffer

Lane buffer between data memory and the SHA-3/Keccak core. Holds one 25×64-bit Keccak state and moves it lane by lane in four directions:
- from data memory into the buffer, driven by `lbuf`;
- from the buffer to data memory, driven by `sbuf`;
- from the buffer into the SHA-3 core (absorb);
- from the SHA-3 core into the buffer (squeeze).

The pipeline's buffer-stall logic holds the CPU until this block raises `done`.

## Interface
Parameters:
- `LANES`, 25: number of lanes per state.
- `W`, 64: lane width in bits.
- `IDX_W`, 5: lane index width; must satisfy 2^IDX_W ≥ LANES.

Ports:
- `CLK` in 1: single clock; all logic is rising-edge.
- `RST` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_op` in 2: command code. 00 = LOAD (dmem→buf), 01 = STORE (buf→dmem), 10 = ABSORB (buf→core), 11 = SQUEEZE (core→buf).
- `cmd_base` in 64: byte base address in dmem, used only by LOAD and STORE.
- `cmd_ready` out 1: high only in IDLE.
- `dmem_addr` out 64: dmem byte address.
- `dmem_re` out 1: dmem read strobe.
- `dmem_we` out 1: dmem write strobe.
- `dmem_wdata` out W: dmem write data.
- `dmem_rdata` in W: dmem read data, valid the cycle after `dmem_re`.
- `core_out_valid` / `core_out_data[W]` out, `core_out_ready` in: lane stream from buffer to core.
- `core_in_valid` / `core_in_data[W]` in, `core_in_ready` out: lane stream from core to buffer.
- `lane_idx` out IDX_W: current lane index, used as the buffer offset.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
Command acceptance:
- A command is accepted on a cycle where `cmd_valid && cmd_ready`.
- On acceptance: `cmd_op` and `cmd_base` are latched, `lane_idx` is cleared to 0, and the FSM leaves IDLE.
- `cmd_valid` is ignored while `busy`.

FSM states: IDLE, LOAD, LOAD_LAST, STORE, ABSORB, SQUEEZE, DONE.
- IDLE → LOAD / STORE / ABSORB / SQUEEZE on acceptance, selected by `cmd_op`.
- LOAD:
  - Every cycle: `dmem_re=1`, `dmem_addr = base + 8*lane_idx`.
  - The read data for lane k is written to lane k on the following cycle, using a registered write index.
  - After issuing lane LANES-1, go to LOAD_LAST.
- LOAD_LAST: no read is issued; capture the final lane; go to DONE.
- STORE:
  - Every cycle: `dmem_we=1`, `dmem_addr = base + 8*lane_idx`, `dmem_wdata = lane[lane_idx]`.
  - After lane LANES-1, go to DONE.
- ABSORB:
  - `core_out_valid=1`, `core_out_data = lane[lane_idx]`.
  - `lane_idx` advances only on `core_out_valid && core_out_ready`.
  - After the handshake on lane LANES-1, go to DONE.
- SQUEEZE:
  - `core_in_ready=1`.
  - On `core_in_valid`, `lane[lane_idx] <= core_in_data` and `lane_idx` advances.
  - After lane LANES-1, go to DONE.
- DONE: `done=1` for exactly one cycle, `lane_idx` cleared to 0, go to IDLE.

Arithmetic and boundaries:
- Address is `base + (lane_idx << 3)`, computed in 64 bits and wrapping modulo 2^64.
- `lane_idx` never exceeds LANES-1; it does not wrap within a command.
- Lanes not touched by the current command keep their value.
- While ABSORB has `core_out_valid && !core_out_ready`, `core_out_data` and `lane_idx` hold stable.
- `dmem_re`, `dmem_we`, `core_out_valid` and `core_in_ready` are 0 outside their respective states.

Reset:
- On `RST=1`, at any time including mid-command, the next edge applies: FSM = IDLE, `lane_idx`=0, all lanes = 0, and all outputs are 0 except `cmd_ready`=1 (its IDLE value).
- The aborted command produces no `done`.
- After `RST` deasserts, a command may be accepted on the first cycle.

## Timing
Reset values:
- `cmd_ready`=1.
- `busy`=0, `done`=0, `lane_idx`=0.
- `dmem_re`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0.
- `core_out_valid`=0, `core_out_data`=0, `core_in_ready`=0.

Latencies, counted as cycles from the acceptance edge to `done`:
- LOAD: LANES+2 cycles (27); the last lane is written on the LOAD_LAST edge.
- STORE: LANES+1 cycles (26).
- ABSORB / SQUEEZE: LANES+1 cycles minimum; each stalled handshake cycle adds one.

Other rules:
- `cmd_ready` rises the cycle after `done`, so back-to-back commands have a one-cycle gap.
- Lane writes are visible on `dmem_wdata` / `core_out_data` on the cycle after the write edge.
- All outputs are registered or decoded only from state, `lane_idx` and lane registers; there is no combinational path from inputs to outputs except `dmem_rdata` into lane storage.

## Test plan
- **Reset check:** assert `RST` 2 cycles → all outputs at reset values and `cmd_ready`=1. Then STORE at base 0x1000 → 25 writes at 0x1000..0x10C0, all data 0, `done` at cycle 26.
- **LOAD then STORE:** dmem preloaded with word i = 0xA5A5_0000_0000_0000 + i at 0x2000+8i. LOAD at base 0x2000, then STORE at base 0x3000 → 0x3000+8i holds the same words; `done` at cycles 27 and 26.
- **ABSORB with backpressure:** lanes hold i. `core_out_ready` follows the pattern 1,0,0,1,… → lanes 0..24 are delivered exactly once in order; data is stable while stalled; `done` comes after the 25th handshake.
- **SQUEEZE with gaps:** `core_in_valid` is high on alternate cycles with data 0xDEAD_BEEF_0000_0000 + i. Then STORE → dmem receives exactly those 25 values.
- **Address wrap:** LOAD at base 0xFFFF_FFFF_FFFF_FFF0 → read addresses …FFF0, …FFF8, 0x0, 0x8, … 0xB0.
- **Mid-command reset and ignored command:** assert `RST` at lane 10 of a STORE → next cycle the FSM is IDLE, `dmem_we`=0, no `done`. Separately, `cmd_valid` pulsed during ABSORB → ignored, and ABSORB completes normally.
